vga_timing_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 25 ++
 rtl/vga_axis_counter.sv | 40 ++++
 rtl/vga_timing_gen.sv | 124 ++++++++++++
 tb/tb_vga_timing_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the 640x480@60 VGA timing generator: default porch and
// sync widths, derived totals, coordinate width and a window-decode helper.
package vga_pkg;

  localparam int COORD_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FRONT   = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BACK    = 48;
  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FRONT   = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BACK    = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

  // True when lo <= val < lo+len; used for both sync pulse windows.
  function automatic logic in_window(input logic [COORD_W-1:0] val,
                                     input int lo, input int len);
    return (int'(val) >= lo) && (int'(val) < lo + len);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Modulo-TOTAL counter with enable and synchronous clear. wrap_o is high in the
// cycle where an enabled count sits at TOTAL-1, i.e. the edge it returns to 0.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = 800
) (
  input  logic               clk,
  input  logic               clr_i,
  input  logic               en_i,
  output logic [COORD_W-1:0] cnt_o,
  output logic               wrap_o
);

  localparam logic [COORD_W-1:0] LAST = COORD_W'(TOTAL - 1);

  logic [COORD_W-1:0] cnt_q;
  logic [COORD_W-1:0] cnt_d;

  assign wrap_o = en_i && (cnt_q == LAST);
  assign cnt_o  = cnt_q;

  // Next count: clear wins, then explicit wrap at TOTAL-1, else increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (wrap_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing from the 25 MHz pixel clock. Counters are held
// at (0,0) while reset is high or the clock generator is not locked; all pins
// are registered decodes of the counter state (one cycle of latency).
// Optional macro VGA_FRAME_CNT_EN adds an 8-bit frame_count output.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FRONT   = DEF_H_FRONT,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BACK    = DEF_H_BACK,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FRONT   = DEF_V_FRONT,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BACK    = DEF_V_BACK
) (
  input  logic               clk25,
  input  logic               reset,
  input  logic               locked,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic [COORD_W-1:0] pixel_x,
  output logic [COORD_W-1:0] pixel_y,
  output logic               frame_start
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [7:0]         frame_count
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Loss of lock is treated exactly like reset: the frame is abandoned.
  logic clr;
  assign clr = reset || !locked;

  logic [COORD_W-1:0] h_cnt;
  logic [COORD_W-1:0] v_cnt;
  logic               h_wrap;
  // Frame boundary is decoded from (0,0), so the vertical wrap is not needed.
  logic               v_wrap_unused;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk    (clk25),
    .clr_i  (clr),
    .en_i   (1'b1),
    .cnt_o  (h_cnt),
    .wrap_o (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk    (clk25),
    .clr_i  (clr),
    .en_i   (h_wrap),
    .cnt_o  (v_cnt),
    .wrap_o (v_wrap_unused)
  );

  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               video_on_q, video_on_d;
  logic               frame_start_q, frame_start_d;
  logic [COORD_W-1:0] pixel_x_q, pixel_x_d;
  logic [COORD_W-1:0] pixel_y_q, pixel_y_d;

  // Decode the current counter state; reset values while cleared.
  always_comb begin
    hsync_d       = 1'b1;
    vsync_d       = 1'b1;
    video_on_d    = 1'b0;
    frame_start_d = 1'b0;
    pixel_x_d     = '0;
    pixel_y_d     = '0;
    if (!clr) begin
      hsync_d       = !in_window(h_cnt, H_VISIBLE + H_FRONT, H_SYNC);
      vsync_d       = !in_window(v_cnt, V_VISIBLE + V_FRONT, V_SYNC);
      video_on_d    = (int'(h_cnt) < H_VISIBLE) && (int'(v_cnt) < V_VISIBLE);
      frame_start_d = (h_cnt == '0) && (v_cnt == '0);
      pixel_x_d     = h_cnt;
      pixel_y_d     = v_cnt;
    end
  end

  // Output registers keep every pin aligned to the same counter sample.
  always_ff @(posedge clk25) begin
    hsync_q       <= hsync_d;
    vsync_q       <= vsync_d;
    video_on_q    <= video_on_d;
    frame_start_q <= frame_start_d;
    pixel_x_q     <= pixel_x_d;
    pixel_y_q     <= pixel_y_d;
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign frame_start = frame_start_q;
  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;

`ifdef VGA_FRAME_CNT_EN
  logic [7:0] frame_count_q, frame_count_d;

  // Count frames: step once per frame_start output cycle, wrap 255->0.
  always_comb begin
    frame_count_d = frame_count_q;
    if (clr) begin
      frame_count_d = '0;
    end else if (frame_start_q) begin
      frame_count_d = frame_count_q + 8'd1;
    end
  end

  // Frame counter register.
  always_ff @(posedge clk25) begin
    frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line timing and a
// shrunken-raster instance for frame-level timing, both checked every cycle
// against an arithmetic model (position = cycles since start mod totals).
module tb_vga_timing_gen;

  // Shrunken raster: 16 clocks per line, 13 lines per frame.
  localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 3;
  localparam int S_VV = 6, S_VF = 2, S_VS = 2, S_VB = 3;
  localparam int S_HT = S_HV + S_HF + S_HS + S_HB;
  localparam int S_FT = S_HT * (S_VV + S_VF + S_VS + S_VB);
  localparam int N_FRAMES = 257;

  logic clk25  = 1'b0;
  logic reset  = 1'b1;
  logic locked = 1'b1;

  logic       d_hs, d_vs, d_von, d_fs;
  logic [9:0] d_px, d_py;
  logic       s_hs, s_vs, s_von, s_fs;
  logic [9:0] s_px, s_py;
`ifdef VGA_FRAME_CNT_EN
  logic [7:0] d_fc, s_fc;
`endif

  always #20 clk25 = ~clk25;

  vga_timing_gen dut (
    .clk25(clk25), .reset(reset), .locked(locked),
    .hsync(d_hs), .vsync(d_vs), .video_on(d_von),
    .pixel_x(d_px), .pixel_y(d_py), .frame_start(d_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(d_fc)
`endif
  );

  vga_timing_gen #(
    .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) dut_s (
    .clk25(clk25), .reset(reset), .locked(locked),
    .hsync(s_hs), .vsync(s_vs), .video_on(s_von),
    .pixel_x(s_px), .pixel_y(s_py), .frame_start(s_fs)
`ifdef VGA_FRAME_CNT_EN
    , .frame_count(s_fc)
`endif
  );

  typedef struct {
    logic hs, vs, von, fs;
    int   px, py, fc;
  } exp_t;

  typedef struct {
    logic rst, lck;
    int   cycles;
    logic hs, vs, von;
    int   px, py;
    logic fs;
  } vec_t;

  int tests = 0;
  int fails = 0;

  // Edges since counting started; -1 while held in reset / unlocked.
  int n_edge = -1;
  always @(posedge clk25) begin
    if (reset || !locked) n_edge = -1;
    else                  n_edge = n_edge + 1;
  end

  // Expected pins after edge n: outputs show the raster position n clocks in.
  function automatic exp_t model(int n, int hv, int hf, int hs, int hb,
                                 int vv, int vf, int vs, int vb);
    exp_t e;
    int ht, vt, ft, h, v;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    ft = ht * vt;
    e = '{hs: 1'b1, vs: 1'b1, von: 1'b0, fs: 1'b0, px: 0, py: 0, fc: 0};
    if (n >= 0) begin
      h = n % ht;
      v = (n / ht) % vt;
      e.px  = h;
      e.py  = v;
      e.hs  = !((h >= hv + hf) && (h < hv + hf + hs));
      e.vs  = !((v >= vv + vf) && (v < vv + vf + vs));
      e.von = (h < hv) && (v < vv);
      e.fs  = (n % ft) == 0;
      e.fc  = ((n + ft - 1) / ft) % 256;
    end
    return e;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string name, input exp_t e, input logic hs,
                           input logic vs, input logic von, input logic fs,
                           input int px, input int py, input int fc);
    tests++;
    if (hs !== e.hs || vs !== e.vs || von !== e.von || fs !== e.fs ||
        px != e.px || py != e.py || fc != e.fc) begin
      fails++;
      $display("FAIL %s n=%0d: got hs=%b vs=%b von=%b fs=%b x=%0d y=%0d fc=%0d, expected hs=%b vs=%b von=%b fs=%b x=%0d y=%0d fc=%0d",
               name, n_edge, hs, vs, von, fs, px, py, fc,
               e.hs, e.vs, e.von, e.fs, e.px, e.py, e.fc);
    end
  endtask

  task automatic check_model();
    exp_t ed, es;
    int dfc, sfc;
    ed = model(n_edge, 640, 16, 96, 48, 480, 10, 2, 33);
    es = model(n_edge, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB);
`ifdef VGA_FRAME_CNT_EN
    dfc = int'(d_fc);
    sfc = int'(s_fc);
`else
    dfc = ed.fc;
    sfc = es.fc;
`endif
    cmp_model("model_full", ed, d_hs, d_vs, d_von, d_fs, int'(d_px), int'(d_py), dfc);
    cmp_model("model_small", es, s_hs, s_vs, s_von, s_fs, int'(s_px), int'(s_py), sfc);
  endtask

  task automatic step();
    @(posedge clk25);
    @(negedge clk25);
    check_model();
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hsync"}, int'(d_hs), 1);
    chk({tag, "_vsync"}, int'(d_vs), 1);
    chk({tag, "_video_on"}, int'(d_von), 0);
    chk({tag, "_pixel_x"}, int'(d_px), 0);
    chk({tag, "_pixel_y"}, int'(d_py), 0);
    chk({tag, "_frame_start"}, int'(d_fs), 0);
  endtask

  vec_t tbl[10];

  initial begin
    int von_cnt, hs_low, hs_min, hs_max;
    int last_fs, vs_low, pulses;

    // inputs, cycles, expected hs, vs, video_on, x, y, frame_start (full size)
    tbl[0] = '{1'b1, 1'b1,   5, 1'b1, 1'b1, 1'b0,   0, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 300, 1'b1, 1'b1, 1'b0,   0, 0, 1'b0};
    tbl[2] = '{1'b0, 1'b1,   1, 1'b1, 1'b1, 1'b1,   0, 0, 1'b1};
    tbl[3] = '{1'b0, 1'b1,   1, 1'b1, 1'b1, 1'b1,   1, 0, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 654, 1'b1, 1'b1, 1'b0, 655, 0, 1'b0};
    tbl[5] = '{1'b0, 1'b1,   1, 1'b0, 1'b1, 1'b0, 656, 0, 1'b0};
    tbl[6] = '{1'b0, 1'b1,  95, 1'b0, 1'b1, 1'b0, 751, 0, 1'b0};
    tbl[7] = '{1'b0, 1'b1,   1, 1'b1, 1'b1, 1'b0, 752, 0, 1'b0};
    tbl[8] = '{1'b0, 1'b1,  47, 1'b1, 1'b1, 1'b0, 799, 0, 1'b0};
    tbl[9] = '{1'b0, 1'b1,   1, 1'b1, 1'b1, 1'b1,   0, 1, 1'b0};

    for (int i = 0; i < 10; i++) begin
      reset  = tbl[i].rst;
      locked = tbl[i].lck;
      steps(tbl[i].cycles);
      chk($sformatf("vec%0d_hsync", i), int'(d_hs), int'(tbl[i].hs));
      chk($sformatf("vec%0d_vsync", i), int'(d_vs), int'(tbl[i].vs));
      chk($sformatf("vec%0d_video_on", i), int'(d_von), int'(tbl[i].von));
      chk($sformatf("vec%0d_pixel_x", i), int'(d_px), tbl[i].px);
      chk($sformatf("vec%0d_pixel_y", i), int'(d_py), tbl[i].py);
      chk($sformatf("vec%0d_frame_start", i), int'(d_fs), int'(tbl[i].fs));
    end

    // One whole line (line 1): video_on run length and hsync window.
    von_cnt = 0; hs_low = 0; hs_min = 9999; hs_max = -1;
    for (int c = 0; c < 800; c++) begin
      if (d_von) von_cnt++;
      if (!d_hs) begin
        hs_low++;
        if (int'(d_px) < hs_min) hs_min = int'(d_px);
        if (int'(d_px) > hs_max) hs_max = int'(d_px);
      end
      if (c < 799) step();
    end
    chk("line_video_on_cycles", von_cnt, 640);
    chk("line_hsync_low_cycles", hs_low, 96);
    chk("line_hsync_first_x", hs_min, 656);
    chk("line_hsync_last_x", hs_max, 751);
    chk("line_end_x", int'(d_px), 799);
    step();
    chk("line_wrap_x", int'(d_px), 0);
    chk("line_wrap_y", int'(d_py), 2);

    // Lock drop mid-frame at (320,2).
    steps(320);
    chk("pre_drop_x", int'(d_px), 320);
    chk("pre_drop_y", int'(d_py), 2);
    locked = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_reset_vals($sformatf("drop%0d", k));
    end
    locked = 1'b1;
    step();
    chk("relock_frame_start", int'(d_fs), 1);
    chk("relock_x", int'(d_px), 0);
    chk("relock_y", int'(d_py), 0);
    step();
    chk("relock_fs_one_cycle", int'(d_fs), 0);

    // Many frames on the small raster: period, vsync width, frame counter.
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    last_fs = -1; vs_low = 0; pulses = 0;
    for (int c = 0; c <= N_FRAMES * S_FT; c++) begin
      if (s_fs) begin
        if (last_fs >= 0) begin
          chk("frame_period", c - last_fs, S_FT);
          chk("frame_vsync_low", vs_low, S_VS * S_HT);
        end
`ifdef VGA_FRAME_CNT_EN
        chk("frame_count_at_start", int'(s_fc), pulses % 256);
`endif
        pulses++;
        last_fs = c;
        vs_low  = 0;
      end
      if (!s_vs) vs_low++;
      step();
    end
    chk("frame_pulses", pulses, N_FRAMES + 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
